ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the RV64I `datapath`.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents them to the datapath through a valid/ready handshake; handles branch/jump redirects and halt.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_ibuf.sv | 59 +++++
 rtl/ifetch_ctrl.sv | 105 ++++++++++
 tb/tb_ifetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the ifetch_ctrl instruction-fetch sequencer
package ifetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int XLEN_RV64   = 64;

    typedef enum logic [2:0] {
        RUN,
        WAIT,
        DRAIN,
        HALTED,
        FAULT
    } state_e;

    typedef struct packed {
        logic [31:0]          instr;
        logic [XLEN_RV64-1:0] pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ifetch_ibuf.sv
// ifetch_ibuf: sync FIFO with flush, push/pop, occupancy count and a registered head that reads 0 when empty
module ifetch_ibuf #(
    parameter int W     = 96,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          head_valid_o,
    output logic [W-1:0]  head_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  head_d;
    logic          do_push, do_pop;

    // Next pointers/count, and the entry that will sit at the head after this cycle
    always_comb begin
        do_pop  = pop_i && cnt_q != '0 && !flush_i;
        do_push = push_i && !flush_i && (cnt_q != CW'(DEPTH) || do_pop);
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
        head_d  = (cnt_d == '0) ? '0 : (do_push && wr_q == rd_d) ? din_i : mem_q[rd_d];
    end

    // Storage write; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // Pointers, count and the registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            head_valid_o <= 1'b0;
            head_o       <= '0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            head_valid_o <= cnt_d != '0;
            head_o       <= head_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch sequencer owning the PC, one outstanding imem request, an instruction buffer, redirect and halt.
// Optional misaligned-redirect fault enabled by defining IFETCH_ALIGN_CHK_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_fault
);

    localparam int CW = $clog2(IBUF_DEPTH) + 1;

    state_e           state_q;
    logic [XLEN-1:0]  fpc_q, req_pc_q, target;
    logic [CW-1:0]    count;
    logic [XLEN+31:0] head;
    logic             accept, push, pop, misalign;

`ifdef IFETCH_ALIGN_CHK_EN
    assign misalign    = redirect_valid && redirect_pc[1:0] != 2'b00;
    assign fetch_fault = state_q == FAULT;
`else
    assign misalign    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Request issue plus buffer push/pop; a redirect cancels both buffer operations
    always_comb begin
        imem_req_valid = !rst && state_q == RUN && !halt && count < CW'(IBUF_DEPTH);
        imem_req_addr  = fpc_q;
        accept         = imem_req_valid && imem_req_ready;
        push           = state_q == WAIT && imem_rsp_valid && !redirect_valid;
        pop            = instr_valid && instr_ready && !redirect_valid;
        target         = redirect_pc & ~XLEN'(3);
    end

    // Fetch FSM: redirect first, then request accept, response completion and halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            fpc_q    <= RESET_PC;
            req_pc_q <= '0;
        end else if (misalign) begin
            state_q <= FAULT;
        end else if (redirect_valid) begin
            fpc_q <= target;
            case (state_q)
                RUN:          state_q <= accept ? DRAIN : RUN;
                WAIT, DRAIN:  state_q <= imem_rsp_valid ? RUN : DRAIN;
                default:      state_q <= state_q;
            endcase
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        fpc_q    <= fpc_q + XLEN'(INSTR_BYTES);
                        req_pc_q <= fpc_q;
                        state_q  <= WAIT;
                    end else if (halt) begin
                        state_q <= HALTED;
                    end
                end
                WAIT:    state_q <= imem_rsp_valid ? (halt ? HALTED : RUN) : WAIT;
                DRAIN:   state_q <= imem_rsp_valid ? RUN : DRAIN;
                HALTED:  state_q <= halt ? HALTED : RUN;
                default: state_q <= state_q;
            endcase
        end
    end

    ifetch_ibuf #(
        .W     (32 + XLEN),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .din_i        ({imem_rsp_data, req_pc_q}),
        .pop_i        (pop),
        .count_o      (count),
        .head_valid_o (instr_valid),
        .head_o       (head)
    );

    assign instr    = head[XLEN+31:XLEN];
    assign instr_pc = head[XLEN-1:0];

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed, table-driven bench for ifetch_ctrl with a 2-cycle-latency imem model
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic        p1_v = 1'b0, p2_v = 1'b0, a_v;
    logic [63:0] p1_a = '0, p2_a = '0, a_a;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rb;
        bit          ir;
        bit          rv;
        logic [63:0] ra;
        bit          iv;
        logic [63:0] ipc;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input bit rb, input bit ir, input bit rv, input logic [63:0] ra,
                                input bit iv, input logic [63:0] ipc);
        vec_t v;
        v.rb = rb; v.ir = ir; v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit ir, input bit hl, input bit rv, input logic [63:0] rpc);
        instr_ready    = ir;
        halt           = hl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rsp_valid = p2_v;
        imem_rsp_data  = p2_v ? data_of(p2_a) : 32'h0;
        #1;
    endtask

    task automatic clock();
        a_v = imem_req_valid && imem_req_ready;
        a_a = imem_req_addr;
        @(posedge clk);
        #1;
        p2_v = p1_v; p2_a = p1_a;
        p1_v = a_v;  p1_a = a_a;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 64'h0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_fetch_fault", fetch_fault, 0);
        clock();
        rst = 1'b0;
    endtask

    task automatic chk_head(input string nm, input bit iv, input logic [63:0] pc);
        chk({nm, ".iv"}, instr_valid, iv);
        chk({nm, ".pc"}, instr_pc, iv ? pc : 64'h0);
        chk({nm, ".instr"}, instr, iv ? data_of(pc) : 32'h0);
    endtask

    initial begin
        // streaming with the consumer always ready: one instruction per 3 cycles
        vecs[0]  = mk(1, 1, 1, 64'h0, 0, 64'h0);
        vecs[1]  = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[2]  = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[3]  = mk(0, 1, 1, 64'h4, 1, 64'h0);
        vecs[4]  = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[5]  = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[6]  = mk(0, 1, 1, 64'h8, 1, 64'h4);
        vecs[7]  = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[8]  = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[9]  = mk(0, 1, 1, 64'hC, 1, 64'h8);
        // consumer stalled 10 cycles: buffer fills to 2, requests stop, then resume at 8
        vecs[10] = mk(1, 0, 1, 64'h0, 0, 64'h0);
        vecs[11] = mk(0, 0, 0, 64'h0, 0, 64'h0);
        vecs[12] = mk(0, 0, 0, 64'h0, 0, 64'h0);
        vecs[13] = mk(0, 0, 1, 64'h4, 1, 64'h0);
        vecs[14] = mk(0, 0, 0, 64'h0, 1, 64'h0);
        vecs[15] = mk(0, 0, 0, 64'h0, 1, 64'h0);
        vecs[16] = mk(0, 0, 0, 64'h0, 1, 64'h0);
        vecs[17] = mk(0, 0, 0, 64'h0, 1, 64'h0);
        vecs[18] = mk(0, 0, 0, 64'h0, 1, 64'h0);
        vecs[19] = mk(0, 0, 0, 64'h0, 1, 64'h0);
        vecs[20] = mk(0, 1, 0, 64'h0, 1, 64'h0);
        vecs[21] = mk(0, 1, 1, 64'h8, 1, 64'h4);
        vecs[22] = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[23] = mk(0, 1, 0, 64'h0, 0, 64'h0);
        vecs[24] = mk(0, 1, 1, 64'hC, 1, 64'h8);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rb) do_reset();
            drive(vecs[i].ir, 0, 0, 64'h0);
            chk($sformatf("vec%0d.req_valid", i), imem_req_valid, vecs[i].rv);
            if (vecs[i].rv) chk($sformatf("vec%0d.req_addr", i), imem_req_addr, vecs[i].ra);
            chk_head($sformatf("vec%0d", i), vecs[i].iv, vecs[i].ipc);
            clock();
        end

        // redirect to 0x100 while the request for 0x8 is outstanding
        do_reset();
        repeat (7) begin drive(1, 0, 0, 64'h0); clock(); end
        drive(1, 0, 1, 64'h100);
        chk("redir_c7.iv", instr_valid, 0);
        clock();
        drive(1, 0, 0, 64'h0);
        chk("drain.req_valid", imem_req_valid, 0);
        chk("drain.iv", instr_valid, 0);
        clock();
        drive(1, 0, 0, 64'h0);
        chk("redir.req_valid", imem_req_valid, 1);
        chk("redir.req_addr", imem_req_addr, 64'h100);
        chk("stale_dropped.iv", instr_valid, 0);
        clock();
        repeat (2) begin drive(1, 0, 0, 64'h0); clock(); end
        drive(1, 0, 0, 64'h0);
        chk_head("redir_target", 1, 64'h100);
        clock();

        // reset while WAIT for 0x104: its late response lands in RUN and must be ignored
        do_reset();
        drive(1, 0, 0, 64'h0);
        chk("postrst.req_valid", imem_req_valid, 1);
        chk("postrst.req_addr", imem_req_addr, 64'h0);
        chk("postrst_c0.iv", instr_valid, 0);
        clock();
        drive(1, 0, 0, 64'h0);
        chk("postrst_c1.iv", instr_valid, 0);
        clock();
        drive(1, 0, 0, 64'h0);
        clock();
        drive(1, 0, 0, 64'h0);
        chk_head("postrst_c3", 1, 64'h0);
        clock();

        // redirect with a simultaneous pop while the buffer holds 0x10,0x14
        do_reset();
        drive(0, 1, 1, 64'h10);
        clock();
        repeat (6) begin drive(0, 0, 0, 64'h0); clock(); end
        drive(1, 0, 1, 64'h200);
        chk("full.req_valid", imem_req_valid, 0);
        chk_head("full_head", 1, 64'h10);
        clock();
        drive(0, 0, 0, 64'h0);
        chk_head("flushed", 0, 64'h0);
        chk("flushed.req_valid", imem_req_valid, 1);
        chk("flushed.req_addr", imem_req_addr, 64'h200);
        clock();
        repeat (2) begin drive(0, 0, 0, 64'h0); clock(); end
        drive(0, 0, 0, 64'h0);
        chk_head("after_flush", 1, 64'h200);
        clock();

        // halt raised while WAIT: response still buffered, no new requests until halt drops
        do_reset();
        drive(0, 0, 0, 64'h0);
        clock();
        drive(0, 1, 0, 64'h0);
        clock();
        drive(0, 1, 0, 64'h0);
        clock();
        drive(1, 1, 0, 64'h0);
        chk_head("halt_head", 1, 64'h0);
        chk("halt_c3.req_valid", imem_req_valid, 0);
        clock();
        for (int k = 4; k < 6; k++) begin
            drive(1, 1, 0, 64'h0);
            chk($sformatf("halt_c%0d.req_valid", k), imem_req_valid, 0);
            clock();
        end
        drive(1, 0, 0, 64'h0);
        chk("unhalt_c6.req_valid", imem_req_valid, 0);
        chk("unhalt_c6.iv", instr_valid, 0);
        clock();
        drive(1, 0, 0, 64'h0);
        chk("resume.req_valid", imem_req_valid, 1);
        chk("resume.req_addr", imem_req_addr, 64'h4);
        clock();

        // misaligned redirect to 0x102
        do_reset();
        drive(0, 1, 1, 64'h102);
        chk("misalign_c0.fault", fetch_fault, 0);
        clock();
`ifdef IFETCH_ALIGN_CHK_EN
        for (int k = 1; k < 5; k++) begin
            drive(0, 0, 0, 64'h0);
            chk($sformatf("fault_c%0d.fault", k), fetch_fault, 1);
            chk($sformatf("fault_c%0d.req_valid", k), imem_req_valid, 0);
            clock();
        end
        do_reset();
        drive(0, 0, 0, 64'h0);
        chk("fault_cleared.req_valid", imem_req_valid, 1);
        chk("fault_cleared.req_addr", imem_req_addr, 64'h0);
        clock();
`else
        drive(0, 0, 0, 64'h0);
        chk("aligned_c1.fault", fetch_fault, 0);
        chk("aligned_c1.req_valid", imem_req_valid, 1);
        chk("aligned_c1.req_addr", imem_req_addr, 64'h100);
        clock();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
